// File: rtl/trafficlight_pkg.sv
// trafficlight_pkg: lamp/phase codes and decode helpers; TRAFFICLIGHT_STRICT_YELLOW_EN makes G->R illegal on every lamp
package trafficlight_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam logic [2:0] PH_0       = 3'd0;
  localparam logic [2:0] PH_1       = 3'd1;
  localparam logic [2:0] PH_2       = 3'd2;
  localparam logic [2:0] PH_3       = 3'd3;
  localparam logic [2:0] PH_4       = 3'd4;
  localparam logic [2:0] PH_UNKNOWN = 3'd7;

`ifdef TRAFFICLIGHT_STRICT_YELLOW_EN
  localparam bit STRICT_YELLOW = 1'b1;
`else
  localparam bit STRICT_YELLOW = 1'b0;
`endif

  function automatic logic lamp_legal(input logic [2:0] c);
    return c == LAMP_GREEN || c == LAMP_YELLOW || c == LAMP_RED;
  endfunction

  // pattern is {S1,S2,S3,S4}
  function automatic logic [2:0] decode_phase(input logic [11:0] p);
    return p == {LAMP_GREEN,  LAMP_GREEN,  LAMP_RED,    LAMP_RED}   ? PH_0 :
           p == {LAMP_GREEN,  LAMP_YELLOW, LAMP_RED,    LAMP_RED}   ? PH_1 :
           p == {LAMP_GREEN,  LAMP_RED,    LAMP_GREEN,  LAMP_RED}   ? PH_2 :
           p == {LAMP_YELLOW, LAMP_RED,    LAMP_YELLOW, LAMP_RED}   ? PH_3 :
           p == {LAMP_RED,    LAMP_RED,    LAMP_RED,    LAMP_GREEN} ? PH_4 : PH_UNKNOWN;
  endfunction

endpackage

// File: rtl/trafficlight_lamp_chk.sv
// trafficlight_lamp_chk: per-lamp history, yellow dwell and encoding/transition checks (G->R policy set by TRAFFICLIGHT_STRICT_YELLOW_EN)
module trafficlight_lamp_chk
  import trafficlight_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter bit IS_S4      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] lamp_i,
  input  logic       prev_valid_i,
  output logic [2:0] prev_o,
  output logic       enc_err_o,
  output logic       seq_err_o,
  output logic       yel_err_o
);

  localparam logic [3:0] MIN_Y = 4'(MIN_YELLOW);

  logic [2:0] prev_q;
  logic [3:0] ycnt_q, ycnt_d;
  logic       chk, step_ok, g2r_ok;

  // classify the step from the previous sample and advance the yellow dwell
  always_comb begin
    g2r_ok    = IS_S4 && !STRICT_YELLOW;
    chk       = prev_valid_i && lamp_legal(lamp_i) && lamp_legal(prev_q);
    step_ok   = lamp_i == prev_q ||
                (prev_q == LAMP_GREEN  && lamp_i == LAMP_YELLOW) ||
                (prev_q == LAMP_YELLOW && lamp_i == LAMP_RED) ||
                (prev_q == LAMP_RED    && lamp_i == LAMP_GREEN) ||
                (prev_q == LAMP_GREEN  && lamp_i == LAMP_RED && g2r_ok);
    enc_err_o = !lamp_legal(lamp_i);
    seq_err_o = chk && !step_ok;
    yel_err_o = chk && prev_q == LAMP_YELLOW && lamp_i == LAMP_RED && ycnt_q < MIN_Y;
    ycnt_d    = lamp_i != LAMP_YELLOW ? 4'd0 :
                (prev_valid_i && prev_q == LAMP_YELLOW) ? (ycnt_q == 4'd15 ? ycnt_q : ycnt_q + 4'd1) : 4'd1;
  end

  // lamp history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 3'd0;
      ycnt_q <= 4'd0;
    end else begin
      prev_q <= lamp_i;
      ycnt_q <= ycnt_d;
    end
  end

  assign prev_o = prev_q;

endmodule

// File: rtl/trafficlight_monitor.sv
// trafficlight_monitor: registered phase decode and sticky safety flags for a 4-lamp junction; TRAFFICLIGHT_STRICT_YELLOW_EN forbids G->R on S4 too
module trafficlight_monitor
  import trafficlight_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_DWELL  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light_S1,
  input  logic [2:0] light_S2,
  input  logic [2:0] light_S3,
  input  logic [2:0] light_S4,
  input  logic       clr,
  output logic [2:0] phase,
  output logic       err_enc,
  output logic       err_conflict,
  output logic       err_seq,
  output logic       err_yellow,
  output logic       err_stuck,
  output logic       err_any
);

  localparam logic [5:0] DWELL_LIMIT = 6'(MAX_DWELL);

  logic [3:0][2:0] lamp_w, prev_w;
  logic [3:0]      enc_w, seq_w, yel_w, nonred_w;
  logic            prev_valid_q;
  logic [4:0]      dwell_q, dwell_d;
  logic [4:0]      err_q, err_d, cond_w;
  logic [2:0]      phase_q;
  logic            err_any_q;

  assign lamp_w = {light_S4, light_S3, light_S2, light_S1};

  for (genvar i = 0; i < 4; i++) begin : g_lamp
    trafficlight_lamp_chk #(
      .MIN_YELLOW(MIN_YELLOW),
      .IS_S4     (i == 3)
    ) u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .lamp_i      (lamp_w[i]),
      .prev_valid_i(prev_valid_q),
      .prev_o      (prev_w[i]),
      .enc_err_o   (enc_w[i]),
      .seq_err_o   (seq_w[i]),
      .yel_err_o   (yel_w[i])
    );
    assign nonred_w[i] = lamp_w[i] != LAMP_RED;
  end

  // pattern dwell and new error conditions; flags are {stuck, yellow, seq, conflict, enc}
  always_comb begin
    dwell_d = (!prev_valid_q || lamp_w != prev_w) ? 5'd1 : (dwell_q == 5'd31 ? dwell_q : dwell_q + 5'd1);
    cond_w  = {{1'b0, dwell_d} > DWELL_LIMIT, |yel_w, |seq_w,
               (nonred_w[3] && |nonred_w[2:0]) || (nonred_w[1] && nonred_w[2]), |enc_w};
    err_d   = (clr ? 5'd0 : err_q) | cond_w;
  end

  // output and sticky-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid_q <= 1'b0;
      dwell_q      <= 5'd0;
      err_q        <= 5'd0;
      err_any_q    <= 1'b0;
      phase_q      <= PH_UNKNOWN;
    end else begin
      prev_valid_q <= 1'b1;
      dwell_q      <= dwell_d;
      err_q        <= err_d;
      err_any_q    <= |err_d;
      phase_q      <= decode_phase({light_S1, light_S2, light_S3, light_S4});
    end
  end

  assign phase        = phase_q;
  assign err_enc      = err_q[0];
  assign err_conflict = err_q[1];
  assign err_seq      = err_q[2];
  assign err_yellow   = err_q[3];
  assign err_stuck    = err_q[4];
  assign err_any      = err_any_q;

endmodule

// File: tb/tb_trafficlight_monitor.sv
// tb_trafficlight_monitor: scoreboard bench with directed scenarios and randomized traffic against a rule-level model
module tb_trafficlight_monitor;

  localparam int MIN_Y = 3;
  localparam int MAX_D = 15;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;
`ifdef TRAFFICLIGHT_STRICT_YELLOW_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] phase;
    logic [4:0] err;
    logic       any;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] light_S1 = R, light_S2 = R, light_S3 = R, light_S4 = R;
  logic       clr = 1'b0;
  logic [2:0] phase;
  logic       err_enc, err_conflict, err_seq, err_yellow, err_stuck, err_any;

  trafficlight_monitor #(.MIN_YELLOW(MIN_Y), .MAX_DWELL(MAX_D)) dut (
    .clk(clk), .rst_n(rst_n),
    .light_S1(light_S1), .light_S2(light_S2), .light_S3(light_S3), .light_S4(light_S4),
    .clr(clr), .phase(phase),
    .err_enc(err_enc), .err_conflict(err_conflict), .err_seq(err_seq),
    .err_yellow(err_yellow), .err_stuck(err_stuck), .err_any(err_any)
  );

  always #5 clk = ~clk;

  logic [11:0] std_pat [5];
  int          std_len [5];
  exp_t        q [$];
  int          n_cmp = 0, n_fail = 0;

  bit         m_valid;
  logic [2:0] m_prev [4];
  int         m_yrun [4];
  int         m_dwell;
  logic [4:0] m_err;
  logic [2:0] cur [4];

  localparam exp_t RST = {3'd7, 5'd0, 1'b0};

  function automatic bit ok(input logic [2:0] c);
    return c == G || c == Y || c == R;
  endfunction

  function automatic bit allowed(input logic [2:0] p, input logic [2:0] c, input int i);
    return p == c || (p == G && c == Y) || (p == Y && c == R) || (p == R && c == G) ||
           (p == G && c == R && i == 3 && !STRICT);
  endfunction

  function automatic logic [2:0] exp_phase();
    for (int k = 0; k < 5; k++)
      if ({cur[0], cur[1], cur[2], cur[3]} == std_pat[k]) return 3'(k);
    return 3'd7;
  endfunction

  function automatic void model_reset();
    m_valid = 0;
    m_dwell = 0;
    m_err   = '0;
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 3'd0;
      m_yrun[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit cl, output exp_t e);
    logic [4:0] c;
    bit         ch;
    bit         nr [4];
    c  = '0;
    ch = !m_valid;
    for (int i = 0; i < 4; i++) begin
      nr[i] = cur[i] != R;
      if (!ok(cur[i])) c[0] = 1'b1;
      if (m_valid && ok(cur[i]) && ok(m_prev[i])) begin
        if (!allowed(m_prev[i], cur[i], i)) c[2] = 1'b1;
        if (m_prev[i] == Y && cur[i] == R && m_yrun[i] < MIN_Y) c[3] = 1'b1;
      end
      if (cur[i] != m_prev[i]) ch = 1;
      m_yrun[i] = cur[i] != Y ? 0 : (m_valid && m_prev[i] == Y) ? (m_yrun[i] < 15 ? m_yrun[i] + 1 : 15) : 1;
      m_prev[i] = cur[i];
    end
    c[1]    = (nr[3] && (nr[0] || nr[1] || nr[2])) || (nr[1] && nr[2]);
    m_dwell = ch ? 1 : (m_dwell < 31 ? m_dwell + 1 : 31);
    c[4]    = m_dwell > MAX_D;
    m_err   = (cl ? 5'd0 : m_err) | c;
    m_valid = 1;
    e = {exp_phase(), m_err, |m_err};
  endfunction

  task automatic step(input logic [11:0] pat, input bit cl);
    exp_t e;
    @(negedge clk);
    {light_S1, light_S2, light_S3, light_S4} = pat;
    cur[0] = pat[11:9];
    cur[1] = pat[8:6];
    cur[2] = pat[5:3];
    cur[3] = pat[2:0];
    clr = cl;
    model_step(cl, e);
    q.push_back(e);
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    #3;
    q.push_back(RST);
    model_reset();
    rst_n = 1'b0;
    repeat (n) begin
      @(negedge clk);
      q.push_back(RST);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_std(input int loops);
    repeat (loops)
      for (int k = 0; k < 5; k++)
        repeat (std_len[k]) step(std_pat[k], 1'b0);
  endtask

  function automatic logic [2:0] rand_lamp();
    return 3'(3'b001 << $urandom_range(0, 2));
  endfunction

  // monitor: compare whenever the DUT presents a response (clock edge or async reset)
  exp_t mon_e, mon_got;
  always begin
    @(posedge clk or negedge rst_n);
    #1;
    if (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_got = {phase, err_stuck, err_yellow, err_seq, err_conflict, err_enc, err_any};
      n_cmp++;
      if (mon_got !== mon_e) begin
        n_fail++;
        $display("FAIL outputs t=%0t rst_n=%b got phase=%0d err(stk,yel,seq,cfl,enc)=%b any=%b need phase=%0d err=%b any=%b",
                 $time, rst_n, mon_got.phase, mon_got.err, mon_got.any, mon_e.phase, mon_e.err, mon_e.any);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int r, idx;
    std_pat[0] = {G, G, R, R}; std_len[0] = 8;
    std_pat[1] = {G, Y, R, R}; std_len[1] = 3;
    std_pat[2] = {G, R, G, R}; std_len[2] = 6;
    std_pat[3] = {Y, R, Y, R}; std_len[3] = 3;
    std_pat[4] = {R, R, R, G}; std_len[4] = 7;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      q.push_back(RST);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_std(2);
    apply_reset(2);
    step(std_pat[0], 0);
    step({G, G, G, R}, 0);
    step({G, G, G, R}, 0);
    apply_reset(1);
    step(std_pat[0], 0);
    repeat (2) step(std_pat[1], 0);
    repeat (2) step(std_pat[2], 0);
    apply_reset(1);
    step(std_pat[0], 0);
    repeat (3) step(std_pat[1], 0);
    repeat (2) step(std_pat[2], 0);
    apply_reset(1);
    repeat (17) step(std_pat[0], 0);
    step(std_pat[1], 1);
    repeat (2) step(std_pat[1], 0);
    repeat (16) step(std_pat[1], 0);
    step(std_pat[1], 1);
    step(std_pat[1], 0);
    apply_reset(1);
    repeat (3) step(std_pat[4], 0);
    repeat (2) step({3'b000, R, R, G}, 0);
    apply_reset(1);
    repeat (2) step(std_pat[0], 0);
    idx = 0;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) apply_reset(int'($urandom_range(1, 2)));
      else if (r < 12) begin
        repeat ($urandom_range(1, 5)) step(std_pat[idx], $urandom_range(0, 9) == 0);
        idx = (idx + 1) % 5;
      end else if (r < 17) step({rand_lamp(), rand_lamp(), rand_lamp(), rand_lamp()}, $urandom_range(0, 7) == 0);
      else step(12'($urandom), $urandom_range(0, 7) == 0);
    end
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d need 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/trafficlight_monitor.md
TRAFFICLIGHT_MONITOR -- requirements
Module: trafficlight_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 3: minimum legal yellow dwell, in cycles.
REQ-002 Parameter MAX_DWELL, default 15: maximum cycles an unchanged light pattern is legal.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 light_S1, light_S2, light_S3, light_S4  input  3 each  lamp codes: 001 green, 010 yellow, 100 red.
REQ-006 clr  input  1  synchronous clear of all sticky error flags.
REQ-007 phase  output  3  decoded phase: 0 (G,G,R,R), 1 (G,Y,R,R), 2 (G,R,G,R), 3 (Y,R,Y,R), 4 (R,R,R,G), 7 any other pattern.
REQ-008 err_enc, err_conflict, err_seq, err_yellow, err_stuck  output  1 each  sticky error flags.
REQ-009 err_any  output  1  registered OR of the five error flags.

Function
REQ-010 All outputs SHALL be registered; response to sampled inputs appears exactly 1 cycle after the sampling edge.
REQ-011 The block SHALL hold a previous-sample register per lamp plus a prev_valid bit; prev_valid clears at reset and sets after the first sample.
REQ-012 err_enc SHALL set when any lamp code is not one of 001/010/100, including 000.
REQ-013 err_conflict SHALL set when S4 is non-red while any of S1..S3 is non-red, or when S2 and S3 are both non-red.
REQ-014 The per-lamp legal transitions SHALL be: hold, G->Y, Y->R, R->G. G->R is legal only as defined in REQ-024/025. Any other change sets err_seq.
REQ-015 Transition checks SHALL be skipped while prev_valid=0, and for any lamp whose current or previous code is illegally encoded.
REQ-016 Each lamp SHALL keep a yellow dwell counter: it resets to 1 on entering yellow, increments while yellow holds, and saturates at 15.
REQ-017 On a Y->R transition with yellow count < MIN_YELLOW, err_yellow SHALL set.
REQ-018 A global dwell counter SHALL reset to 1 on any change of the 12-bit light pattern and increment otherwise, saturating at 31. err_stuck SHALL set when the count exceeds MAX_DWELL.
REQ-019 Error flags SHALL be sticky until clr=1 or reset. When clr coincides with a new error condition, the flag SHALL end set.
REQ-020 phase SHALL update every cycle regardless of error state. Phases T5 and T6 are indistinguishable and both decode to 4.

Reset
REQ-021 While rst_n=0: phase=7, all err_* = 0, err_any=0, prev_valid=0, all counters = 0.
REQ-022 Reset deassertion mid-sequence SHALL restart checking with no transition check on the first sample.
REQ-023 Reset assertion SHALL take effect immediately, independent of clk.

Configuration
REQ-024 With macro TRAFFICLIGHT_STRICT_YELLOW_EN defined, G->R on any lamp SHALL set err_seq.
REQ-025 Without TRAFFICLIGHT_STRICT_YELLOW_EN, G->R SHALL be legal for S4 only; on S1..S3 it sets err_seq.

Structure
REQ-026 Shared package trafficlight_pkg SHALL hold the lamp code constants (LAMP_GREEN, LAMP_YELLOW, LAMP_RED) and the phase code constants (PH_0..PH_4, PH_UNKNOWN=7).
REQ-027 Sub-module trafficlight_lamp_chk SHALL be instantiated 4 times. Each instance holds one lamp's previous code, yellow counter, encoding check and transition check, and takes a parameter marking the S4 instance.

Verification
REQ-028 Drive the standard cycle: (G,G,R,R) 8 cycles, (G,Y,R,R) 3, (G,R,G,R) 6, (Y,R,Y,R) 3, (R,R,R,G) 7, looped twice. Required: phase tracks 0,1,2,3,4; all err_* = 0 with macro undefined.
REQ-029 Same stimulus with TRAFFICLIGHT_STRICT_YELLOW_EN defined. Required: err_seq=1 one cycle after S4 goes 001->100.
REQ-030 Drive S2=001 and S3=001 simultaneously. Required: err_conflict=1 and err_any=1 next cycle; phase=7.
REQ-031 Yellow phase (G,Y,R,R) held 2 cycles, then S2 goes red. Required: err_yellow=1. With the phase held 3 cycles, err_yellow stays 0.
REQ-032 Hold (G,G,R,R) for 17 cycles. Required: err_stuck=1 once the dwell exceeds 15. Then pulse clr with no new error: err_stuck clears on the next cycle. Pulse clr while an error condition persists: the flag remains 1.
REQ-033 Drive light_S1=000, then assert rst_n=0 mid-cycle. Required: err_enc=1 before reset; all outputs at reset values immediately on reset; no err_seq on the first post-reset sample.
